// File: rtl/demux_16_deframer_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_16_deframer_if
// Purpose  : Serial-in / frame-out bus bundle for the 1:16 TDM deframer.
//            The master drives the serial sample stream. The slave (the
//            deframer) returns the assembled frame and its status.
// Revision : 1.0  initial release
// ============================================================================
interface demux_16_deframer_if #(
  parameter int W = 1
);
  logic [W-1:0]    din;
  logic            din_valid;
  logic            sync;
  logic [16*W-1:0] y;
  logic            frame_done;
  logic            frame_err;
  logic            busy;
  logic [3:0]      chan;

  modport master (
    output din, din_valid, sync,
    input  y, frame_done, frame_err, busy, chan
  );

  modport slave (
    input  din, din_valid, sync,
    output y, frame_done, frame_err, busy, chan
  );
endinterface
`default_nettype wire

// File: rtl/demux_16_deframer.sv
`default_nettype none
// ============================================================================
// Module   : demux_16_deframer
// Purpose  : Sequential 1:16 time-division demultiplexer. It collects 16
//            W-bit samples that start at a sync marker. When the frame is
//            complete, all 16 lanes are written to y on one edge.
// Revision : 1.0  initial release
// ============================================================================
module demux_16_deframer #(
  parameter int W = 1
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  demux_16_deframer_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      ptr_q, ptr_d;
  logic [W-1:0]    shadow_q [15];
  logic [W-1:0]    shadow_d [15];
  logic [16*W-1:0] y_q, y_d;
  logic            frame_done_q, frame_done_d;
  logic            frame_err_q, frame_err_d;

  // Next-state logic. A sync restarts the frame even on the 16th sample,
  // so the restart branch is tested before the completion branch.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    shadow_d     = shadow_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    if (bus.din_valid) begin
      case (state_q)
        S_IDLE: begin
          if (bus.sync) begin
            shadow_d[0] = bus.din;
            ptr_d       = 4'd1;
            state_d     = S_FILL;
          end
        end
        S_FILL: begin
          if (bus.sync) begin
            frame_err_d = 1'b1;
            shadow_d[0] = bus.din;
            ptr_d       = 4'd1;
          end else if (ptr_q == 4'd15) begin
            for (int k = 0; k < 15; k++) begin
              y_d[k*W +: W] = shadow_q[k];
            end
            y_d[15*W +: W] = bus.din;
            frame_done_d   = 1'b1;
            ptr_d          = 4'd0;
            state_d        = S_IDLE;
          end else begin
            for (int k = 0; k < 15; k++) begin
              if (ptr_q == 4'(k)) begin
                shadow_d[k] = bus.din;
              end
            end
            ptr_d = ptr_q + 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          ptr_d   = 4'd0;
        end
      endcase
    end
  end

  // State, pointer, shadow and output registers. Reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= 4'd0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int k = 0; k < 15; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      shadow_q     <= shadow_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.y          = y_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q == S_FILL);
  assign bus.chan       = ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_16_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_16_deframer
// Purpose  : Directed bench for demux_16_deframer. It uses a W=4 instance for
//            the frame, reset, early-sync and back-to-back scenarios. It uses
//            a W=1 instance for the gapped-frame scenario.
// Revision : 1.0  initial release
// ============================================================================
module tb_demux_16_deframer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  demux_16_deframer_if #(.W(4)) bus_a ();
  demux_16_deframer_if #(.W(1)) bus_b ();

  demux_16_deframer #(.W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  demux_16_deframer #(.W(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle on the W=4 bus. Outputs are sampled 1ns after the edge.
  task automatic step_a(input logic v, input logic s, input logic [3:0] d);
    bus_a.din = d; bus_a.din_valid = v; bus_a.sync = s;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic v, input logic s, input logic d);
    bus_b.din = d; bus_b.din_valid = v; bus_b.sync = s;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    tests++; if (bus_a.y !== 64'h0) begin fails++; $display("FAIL reset_y: got %h expected 0", bus_a.y); end
    tests++; if (bus_a.busy !== 1'b0 || bus_a.chan !== 4'd0) begin fails++; $display("FAIL reset_busy_chan: got busy=%b chan=%0d expected 0/0", bus_a.busy, bus_a.chan); end
    tests++; if (bus_a.frame_done !== 1'b0 || bus_a.frame_err !== 1'b0) begin fails++; $display("FAIL reset_pulses: got done=%b err=%b expected 0/0", bus_a.frame_done, bus_a.frame_err); end
  endtask

  task automatic test_basic_frame;
    step_a(1'b1, 1'b1, 4'd0);
    tests++; if (bus_a.busy !== 1'b1 || bus_a.chan !== 4'd1) begin fails++; $display("FAIL basic_start: got busy=%b chan=%0d expected 1/1", bus_a.busy, bus_a.chan); end
    for (int k = 1; k < 15; k++) step_a(1'b1, 1'b0, 4'(k));
    tests++; if (bus_a.chan !== 4'd15 || bus_a.frame_done !== 1'b0) begin fails++; $display("FAIL basic_ptr15: got chan=%0d done=%b expected 15/0", bus_a.chan, bus_a.frame_done); end
    step_a(1'b1, 1'b0, 4'd15);
    tests++; if (bus_a.y !== 64'hFEDCBA9876543210) begin fails++; $display("FAIL basic_y: got %h expected FEDCBA9876543210", bus_a.y); end
    tests++; if (bus_a.frame_done !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.chan !== 4'd0) begin fails++; $display("FAIL basic_done: got done=%b busy=%b chan=%0d expected 1/0/0", bus_a.frame_done, bus_a.busy, bus_a.chan); end
    step_a(1'b0, 1'b0, 4'd0);
    tests++; if (bus_a.frame_done !== 1'b0) begin fails++; $display("FAIL basic_pulse_width: got done=%b expected 0", bus_a.frame_done); end
  endtask

  task automatic test_reset_midframe;
    logic saw_done;
    step_a(1'b1, 1'b1, 4'd3);
    for (int k = 1; k < 7; k++) step_a(1'b1, 1'b0, 4'd3);
    tests++; if (bus_a.chan !== 4'd7) begin fails++; $display("FAIL midreset_ptr: got chan=%0d expected 7", bus_a.chan); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus_a.y !== 64'h0 || bus_a.busy !== 1'b0 || bus_a.chan !== 4'd0) begin fails++; $display("FAIL midreset_state: got y=%h busy=%b chan=%0d expected 0/0/0", bus_a.y, bus_a.busy, bus_a.chan); end
    tests++; if (bus_a.frame_done !== 1'b0 || bus_a.frame_err !== 1'b0) begin fails++; $display("FAIL midreset_pulses: got done=%b err=%b expected 0/0", bus_a.frame_done, bus_a.frame_err); end
    #2 rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step_a(1'b1, 1'b0, 4'(k));
      if (bus_a.frame_done === 1'b1) saw_done = 1'b1;
    end
    tests++; if (saw_done !== 1'b0 || bus_a.y !== 64'h0 || bus_a.busy !== 1'b0) begin fails++; $display("FAIL nosync_discard: got done_seen=%b y=%h busy=%b expected 0/0/0", saw_done, bus_a.y, bus_a.busy); end
  endtask

  task automatic test_gapped_frame;
    logic [15:0] pat;
    pat = 16'hA5C3;
    for (int k = 0; k < 16; k++) begin
      step_b(1'b1, (k == 0), pat[k]);
      if (k == 4 || k == 11) begin
        for (int g = 0; g < 3; g++) step_b(1'b0, 1'b1, 1'b1);
        tests++; if (bus_b.chan !== 4'(k + 1) || bus_b.busy !== 1'b1) begin fails++; $display("FAIL gap_hold_%0d: got chan=%0d busy=%b expected %0d/1", k, bus_b.chan, bus_b.busy, k + 1); end
      end
    end
    tests++; if (bus_b.y !== 16'hA5C3 || bus_b.frame_done !== 1'b1) begin fails++; $display("FAIL gap_y: got y=%h done=%b expected a5c3/1", bus_b.y, bus_b.frame_done); end
  endtask

  task automatic test_early_sync;
    logic [3:0] vals [15];
    vals = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2, 4'd5, 4'd8, 4'd11, 4'd14, 4'd1, 4'd4, 4'd7, 4'd10, 4'd13};
    for (int k = 0; k < 16; k++) step_a(1'b1, (k == 0), 4'(15 - k));
    tests++; if (bus_a.y !== 64'h0123456789ABCDEF) begin fails++; $display("FAIL early_frameA: got %h expected 0123456789ABCDEF", bus_a.y); end
    step_a(1'b1, 1'b1, 4'd5);
    for (int k = 1; k < 9; k++) step_a(1'b1, 1'b0, 4'd5);
    tests++; if (bus_a.chan !== 4'd9) begin fails++; $display("FAIL early_ptr9: got chan=%0d expected 9", bus_a.chan); end
    step_a(1'b1, 1'b1, 4'd7);
    tests++; if (bus_a.frame_err !== 1'b1 || bus_a.frame_done !== 1'b0 || bus_a.chan !== 4'd1) begin fails++; $display("FAIL early_err: got err=%b done=%b chan=%0d expected 1/0/1", bus_a.frame_err, bus_a.frame_done, bus_a.chan); end
    tests++; if (bus_a.y !== 64'h0123456789ABCDEF) begin fails++; $display("FAIL early_y_hold: got %h expected 0123456789ABCDEF", bus_a.y); end
    step_a(1'b0, 1'b0, 4'd0);
    tests++; if (bus_a.frame_err !== 1'b0) begin fails++; $display("FAIL early_err_width: got err=%b expected 0", bus_a.frame_err); end
    for (int k = 0; k < 15; k++) step_a(1'b1, 1'b0, vals[k]);
    tests++; if (bus_a.y !== 64'hDA741EB852FC9637 || bus_a.frame_done !== 1'b1) begin fails++; $display("FAIL early_restart_y: got y=%h done=%b expected DA741EB852FC9637/1", bus_a.y, bus_a.frame_done); end
  endtask

  task automatic test_sync_on_16th;
    step_a(1'b1, 1'b1, 4'd1);
    for (int k = 1; k < 15; k++) step_a(1'b1, 1'b0, 4'd2);
    tests++; if (bus_a.chan !== 4'd15) begin fails++; $display("FAIL s16_ptr: got chan=%0d expected 15", bus_a.chan); end
    step_a(1'b1, 1'b1, 4'd9);
    tests++; if (bus_a.frame_err !== 1'b1 || bus_a.frame_done !== 1'b0) begin fails++; $display("FAIL s16_pulses: got err=%b done=%b expected 1/0", bus_a.frame_err, bus_a.frame_done); end
    tests++; if (bus_a.y !== 64'hDA741EB852FC9637 || bus_a.chan !== 4'd1 || bus_a.busy !== 1'b1) begin fails++; $display("FAIL s16_state: got y=%h chan=%0d busy=%b expected DA741EB852FC9637/1/1", bus_a.y, bus_a.chan, bus_a.busy); end
    for (int k = 1; k < 16; k++) step_a(1'b1, 1'b0, 4'(k));
    tests++; if (bus_a.y !== 64'hFEDCBA9876543219 || bus_a.frame_done !== 1'b1) begin fails++; $display("FAIL s16_restart_y: got y=%h done=%b expected FEDCBA9876543219/1", bus_a.y, bus_a.frame_done); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp_y [3];
    int          done_cnt;
    exp_y = '{64'hFEDCBA9876543210, 64'h0FEDCBA987654321, 64'h10FEDCBA98765432};
    for (int f = 0; f < 3; f++) begin
      done_cnt = 0;
      for (int k = 0; k < 16; k++) begin
        step_a(1'b1, (k == 0), 4'(k + f));
        if (bus_a.frame_done === 1'b1) done_cnt++;
      end
      tests++; if (bus_a.frame_done !== 1'b1 || done_cnt != 1 || bus_a.y !== exp_y[f]) begin fails++; $display("FAIL b2b_frame%0d: got y=%h done=%b pulses=%0d expected %h/1/1", f, bus_a.y, bus_a.frame_done, done_cnt, exp_y[f]); end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus_a.din = '0; bus_a.din_valid = 1'b0; bus_a.sync = 1'b0;
    bus_b.din = '0; bus_b.din_valid = 1'b0; bus_b.sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    #2 rst_n = 1'b1;
    step_a(1'b0, 1'b0, 4'd0);
    test_basic_frame;
    test_reset_midframe;
    test_gapped_frame;
    test_early_sync;
    test_sync_on_16th;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
